// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_pkg
// Description : Shared types and constants for the IFU/LSU memory arbiter.
//               - arb_state_t : sequencer states (IDLE/ISSUE/WAIT/RESP)
//               - GNT_IFU / GNT_LSU : grant encoding, also the bit index
//                 of each master in a one-hot grant vector
//               - FUNC3_LW : load-word code used for instruction fetches
//               - mem_req_t : captured request record
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    localparam logic GNT_IFU = 1'b0;
    localparam logic GNT_LSU = 1'b1;

    localparam logic [2:0] FUNC3_LW = 3'b010;

    typedef struct packed {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [2:0]  func3;
    } mem_req_t;

endpackage
`default_nettype wire

// File: rtl/mem_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_rr_arbiter
// Description : Two-input round-robin picker. On a tie the master that did
//               not win last time is chosen. The winner is remembered
//               whenever a grant is issued (a grant is always a handshake,
//               since it is only given to a valid master while enabled).
// Ports       : clk, rst_n         - clock, async active-low reset
//               i_ifu_valid        - IFU requesting
//               i_lsu_valid        - LSU requesting
//               i_enable           - arbitration allowed this cycle
//               o_grant[1:0]       - one-hot grant, indexed by GNT_*
//               o_last_grant       - most recent winner (GNT_* encoding)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_rr_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_ifu_valid,
    input  logic       i_lsu_valid,
    input  logic       i_enable,
    output logic [1:0] o_grant,
    output logic       o_last_grant
);
    import mem_arbiter_pkg::*;

    logic       r_last_grant;
    logic [1:0] w_pick;

    always_comb begin
        w_pick = 2'b00;
        if (i_ifu_valid && i_lsu_valid) begin
            if (r_last_grant == GNT_LSU) begin
                w_pick[GNT_IFU] = 1'b1;
            end else begin
                w_pick[GNT_LSU] = 1'b1;
            end
        end else if (i_ifu_valid) begin
            w_pick[GNT_IFU] = 1'b1;
        end else if (i_lsu_valid) begin
            w_pick[GNT_LSU] = 1'b1;
        end
    end

    assign o_grant      = i_enable ? w_pick : 2'b00;
    assign o_last_grant = r_last_grant;

    // Reset to LSU so that the IFU wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= GNT_LSU;
        end else if (|o_grant) begin
            r_last_grant <= o_grant[GNT_LSU] ? GNT_LSU : GNT_IFU;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Arbitrates the shared memory port between the IFU (read
//               only) and the LSU (read/write). One transaction runs to
//               completion at a time: IDLE -> ISSUE -> WAIT -> RESP. A
//               response timeout in WAIT returns ERR_RDATA with err=1.
// Ports       : clk, rst_n                 - clock, async active-low reset
//               ifu_req_* / ifu_resp_*     - IFU request/response channels
//               lsu_req_* / lsu_resp_*     - LSU request/response channels
//               mem_req_* / mem_resp_*     - memory request/response side
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = 32'hdead_beef
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [31:0] ifu_addr,
    output logic        ifu_resp_valid,
    input  logic        ifu_resp_ready,
    output logic [31:0] ifu_rdata,
    output logic        ifu_resp_err,
    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic [31:0] lsu_addr,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wmask,
    input  logic [2:0]  lsu_func3,
    output logic        lsu_resp_valid,
    input  logic        lsu_resp_ready,
    output logic [31:0] lsu_rdata,
    output logic        lsu_resp_err,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_wen,
    output logic [3:0]  mem_wmask,
    output logic [2:0]  mem_func3,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_rdata
);
    import mem_arbiter_pkg::*;

    localparam logic [15:0] c_TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    arb_state_t  r_state;
    mem_req_t    r_req;
    logic [15:0] r_wait_cnt;
    logic [31:0] r_rdata;
    logic        r_err;
    logic        r_mem_req_valid;
    logic        r_ifu_resp_valid;
    logic        r_lsu_resp_valid;

    logic [1:0]  w_grant;
    logic        w_owner;
    logic        w_arb_en;
    logic        w_resp_ready;
    mem_req_t    w_new_req;

    // Gating with rst_n keeps req_ready low while reset is held, even
    // though the FSM already sits in IDLE.
    assign w_arb_en = (r_state == ST_IDLE) && rst_n;

    mem_rr_arbiter u_rr (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_ifu_valid  (ifu_req_valid),
        .i_lsu_valid  (lsu_req_valid),
        .i_enable     (w_arb_en),
        .o_grant      (w_grant),
        .o_last_grant (w_owner)
    );

    // The last winner is, by construction, the owner of the transaction
    // currently in flight.
    assign w_resp_ready = (w_owner == GNT_LSU) ? lsu_resp_ready : ifu_resp_ready;

    always_comb begin
        if (w_grant[GNT_LSU]) begin
            w_new_req = '{addr: lsu_addr, wen: lsu_wen, wdata: lsu_wdata,
                          wmask: lsu_wmask, func3: lsu_func3};
        end else begin
            w_new_req = '{addr: ifu_addr, wen: 1'b0, wdata: 32'h0,
                          wmask: 4'h0, func3: FUNC3_LW};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= ST_IDLE;
            r_req            <= '0;
            r_wait_cnt       <= '0;
            r_rdata          <= '0;
            r_err            <= 1'b0;
            r_mem_req_valid  <= 1'b0;
            r_ifu_resp_valid <= 1'b0;
            r_lsu_resp_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|w_grant) begin
                        r_req           <= w_new_req;
                        r_mem_req_valid <= 1'b1;
                        r_state         <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (mem_req_ready) begin
                        r_mem_req_valid <= 1'b0;
                        r_wait_cnt      <= '0;
                        r_state         <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    r_wait_cnt <= r_wait_cnt + 16'd1;
                    // A response arriving on the last allowed cycle beats
                    // the timeout.
                    if (mem_resp_valid || (r_wait_cnt == c_TIMEOUT_LAST)) begin
                        if (mem_resp_valid) begin
                            r_rdata <= r_req.wen ? 32'h0 : mem_rdata;
                            r_err   <= 1'b0;
                        end else begin
                            r_rdata <= ERR_RDATA;
                            r_err   <= 1'b1;
                        end
                        r_ifu_resp_valid <= (w_owner == GNT_IFU);
                        r_lsu_resp_valid <= (w_owner == GNT_LSU);
                        r_state          <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (w_resp_ready) begin
                        r_ifu_resp_valid <= 1'b0;
                        r_lsu_resp_valid <= 1'b0;
                        r_state          <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ifu_req_ready  = w_grant[GNT_IFU];
    assign lsu_req_ready  = w_grant[GNT_LSU];

    assign ifu_resp_valid = r_ifu_resp_valid;
    assign ifu_rdata      = r_rdata;
    assign ifu_resp_err   = r_err;
    assign lsu_resp_valid = r_lsu_resp_valid;
    assign lsu_rdata      = r_rdata;
    assign lsu_resp_err   = r_err;

    assign mem_req_valid  = r_mem_req_valid;
    assign mem_addr       = r_req.addr;
    assign mem_wdata      = r_req.wdata;
    assign mem_wen        = r_req.wen;
    assign mem_wmask      = r_req.wmask;
    assign mem_func3      = r_req.func3;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter. A small reference model
//               (round-robin winner, response value/latency rules) predicts
//               every observation; directed and randomized transactions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int          c_TIMEOUT = 4;
    localparam logic [31:0] c_ERR     = 32'hdead_beef;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ifu_req_valid = 1'b0, ifu_req_ready, ifu_resp_valid, ifu_resp_ready = 1'b0, ifu_resp_err;
    logic [31:0] ifu_addr = '0, ifu_rdata;
    logic        lsu_req_valid = 1'b0, lsu_req_ready, lsu_wen = 1'b0, lsu_resp_valid, lsu_resp_ready = 1'b0, lsu_resp_err;
    logic [31:0] lsu_addr = '0, lsu_wdata = '0, lsu_rdata;
    logic [3:0]  lsu_wmask = '0;
    logic [2:0]  lsu_func3 = '0;
    logic        mem_req_valid, mem_req_ready = 1'b0, mem_wen, mem_resp_valid = 1'b0;
    logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
    logic [3:0]  mem_wmask;
    logic [2:0]  mem_func3;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT_CYCLES(c_TIMEOUT), .ERR_RDATA(c_ERR)) dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready),
        .ifu_rdata(ifu_rdata), .ifu_resp_err(ifu_resp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask), .lsu_func3(lsu_func3),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready),
        .lsu_rdata(lsu_rdata), .lsu_resp_err(lsu_resp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen),
        .mem_wmask(mem_wmask), .mem_func3(mem_func3),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit m_last_lsu = 1'b1;   // model: most recent winner was the LSU

    typedef struct packed {
        bit          acc_ifu;
        bit          acc_lsu;
        bit          mrv;
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [2:0]  func3;
        int          wait_len;
        bit          ifu_rv;
        bit          lsu_rv;
        logic [31:0] rdata;
        logic        err;
        int          extra_ready;
        bit          stable;
        bit          idle_after;
    } obs_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        ifu_resp_ready = 1'b0; lsu_resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_last_lsu = 1'b1;
        tick();
    endtask

    // Model: who should win given the two valids.
    function automatic bit exp_lsu_wins(input bit iv, input bit lv);
        if (iv && lv) return !m_last_lsu;
        return lv;
    endfunction

    // Runs one complete transaction from an IDLE cycle and records what the
    // DUT did. rdelay: WAIT cycle index of the memory response, -1 = never.
    task automatic drive_txn(input bit iv, input bit lv, input logic [31:0] iaddr,
                             input logic [31:0] laddr, input logic lwen, input logic [31:0] lwdata,
                             input logic [3:0] lwmask, input logic [2:0] lf3, input int stall,
                             input int rdelay, input logic [31:0] mdata, input int bp,
                             output obs_t o);
        bit win_lsu;
        o = '0;
        o.wait_len = -1;
        ifu_req_valid = iv; ifu_addr = iaddr;
        lsu_req_valid = lv; lsu_addr = laddr; lsu_wen = lwen;
        lsu_wdata = lwdata; lsu_wmask = lwmask; lsu_func3 = lf3;
        #1;
        o.acc_ifu = ifu_req_ready;
        o.acc_lsu = lsu_req_ready;
        win_lsu = lsu_req_ready;
        tick();
        if (win_lsu) lsu_req_valid = 1'b0; else ifu_req_valid = 1'b0;
        for (int s = 0; s < stall; s++) begin
            #1;
            o.extra_ready += int'(ifu_req_ready) + int'(lsu_req_ready);
            tick();
        end
        #1;
        o.extra_ready += int'(ifu_req_ready) + int'(lsu_req_ready);
        o.mrv = mem_req_valid; o.addr = mem_addr; o.wen = mem_wen;
        o.wdata = mem_wdata; o.wmask = mem_wmask; o.func3 = mem_func3;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (c == rdelay) begin
                mem_resp_valid = 1'b1;
                mem_rdata = mdata;
            end
            #1;
            o.extra_ready += int'(ifu_req_ready) + int'(lsu_req_ready);
            tick();
            mem_resp_valid = 1'b0;
            mem_rdata = $urandom;
            if (ifu_resp_valid || lsu_resp_valid) begin
                o.wait_len = c + 1;
                break;
            end
        end
        o.ifu_rv = ifu_resp_valid;
        o.lsu_rv = lsu_resp_valid;
        o.rdata  = lsu_resp_valid ? lsu_rdata : ifu_rdata;
        o.err    = lsu_resp_valid ? lsu_resp_err : ifu_resp_err;
        o.stable = 1'b1;
        for (int b = 0; b < bp; b++) begin
            #1;
            o.extra_ready += int'(ifu_req_ready) + int'(lsu_req_ready);
            tick();
            if ({ifu_resp_valid, lsu_resp_valid} !== {o.ifu_rv, o.lsu_rv} ||
                (o.lsu_rv ? lsu_rdata : ifu_rdata) !== o.rdata ||
                (o.lsu_rv ? lsu_resp_err : ifu_resp_err) !== o.err)
                o.stable = 1'b0;
        end
        #1;
        o.extra_ready += int'(ifu_req_ready) + int'(lsu_req_ready);
        ifu_resp_ready = 1'b1; lsu_resp_ready = 1'b1;
        tick();
        ifu_resp_ready = 1'b0; lsu_resp_ready = 1'b0;
        o.idle_after = !ifu_resp_valid && !lsu_resp_valid && !mem_req_valid;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
        #3;
        n_checks++; if ({ifu_req_ready, lsu_req_ready, mem_req_valid, ifu_resp_valid, lsu_resp_valid} !== 5'b0)
            $display("FAIL reset_ctrl: got %b expected 00000", {ifu_req_ready, lsu_req_ready, mem_req_valid, ifu_resp_valid, lsu_resp_valid}); else n_pass++;
        n_checks++; if ({mem_addr, mem_wdata, ifu_rdata, lsu_rdata} !== 128'h0)
            $display("FAIL reset_data: got %h expected 0", {mem_addr, mem_wdata, ifu_rdata, lsu_rdata}); else n_pass++;
        n_checks++; if ({mem_wen, mem_wmask, mem_func3, ifu_resp_err, lsu_resp_err} !== 10'h0)
            $display("FAIL reset_fields: got %h expected 0", {mem_wen, mem_wmask, mem_func3, ifu_resp_err, lsu_resp_err}); else n_pass++;
        do_reset();
    endtask

    task automatic test_ifu_read();
        obs_t o;
        drive_txn(1'b1, 1'b0, 32'h8000_0000, 32'h0, 1'b0, 32'h0, 4'h0, 3'h0, 0, 1, 32'h0000_0413, 0, o);
        m_last_lsu = 1'b0;
        n_checks++; if ({o.acc_ifu, o.acc_lsu, o.mrv} !== 3'b101)
            $display("FAIL ifu_accept: got %b expected 101", {o.acc_ifu, o.acc_lsu, o.mrv}); else n_pass++;
        n_checks++; if ({o.addr, o.wen, o.wmask, o.func3} !== {32'h8000_0000, 1'b0, 4'h0, 3'b010})
            $display("FAIL ifu_mem_fields: got %h/%b/%b/%b expected 80000000/0/0000/010", o.addr, o.wen, o.wmask, o.func3); else n_pass++;
        n_checks++; if ({o.ifu_rv, o.lsu_rv, o.err, o.rdata} !== {3'b100, 32'h0000_0413})
            $display("FAIL ifu_resp: got v=%b%b err=%b rdata=%h expected 10/0/00000413", o.ifu_rv, o.lsu_rv, o.err, o.rdata); else n_pass++;
        n_checks++; if (o.wait_len !== 2)
            $display("FAIL ifu_wait_len: got %0d expected 2", o.wait_len); else n_pass++;
        n_checks++; if ({o.idle_after, o.extra_ready} !== {1'b1, 32'd0})
            $display("FAIL ifu_finish: got idle=%b extra_ready=%0d expected 1/0", o.idle_after, o.extra_ready); else n_pass++;
    endtask

    task automatic test_lsu_store();
        obs_t o;
        drive_txn(1'b0, 1'b1, 32'h0, 32'h8000_1000, 1'b1, 32'h1234_5678, 4'b0011, 3'b001, 1, 0, 32'hffff_ffff, 0, o);
        m_last_lsu = 1'b1;
        n_checks++; if ({o.acc_ifu, o.acc_lsu} !== 2'b01)
            $display("FAIL lsu_accept: got %b expected 01", {o.acc_ifu, o.acc_lsu}); else n_pass++;
        n_checks++; if ({o.addr, o.wen, o.wdata, o.wmask, o.func3} !== {32'h8000_1000, 1'b1, 32'h1234_5678, 4'b0011, 3'b001})
            $display("FAIL lsu_mem_fields: got %h/%b/%h/%b/%b expected 80001000/1/12345678/0011/001", o.addr, o.wen, o.wdata, o.wmask, o.func3); else n_pass++;
        n_checks++; if ({o.ifu_rv, o.lsu_rv, o.err, o.rdata, o.wait_len} !== {3'b010, 32'h0, 32'd1})
            $display("FAIL lsu_store_resp: got v=%b%b err=%b rdata=%h wait=%0d expected 01/0/0/1", o.ifu_rv, o.lsu_rv, o.err, o.rdata, o.wait_len); else n_pass++;
    endtask

    task automatic test_back_to_back();
        obs_t o;
        bit   exp_lsu [3] = '{1'b0, 1'b1, 1'b0};
        do_reset();
        for (int t = 0; t < 3; t++) begin
            drive_txn(1'b1, 1'b1, 32'h100 + t, 32'h200 + t, 1'b0, 32'h0, 4'hf, 3'b100, 0, 0, 32'h55 + t, 0, o);
            m_last_lsu = exp_lsu[t];
            n_checks++; if ({o.acc_ifu, o.acc_lsu} !== {!exp_lsu[t], exp_lsu[t]})
                $display("FAIL rr_grant[%0d]: got %b expected %b", t, {o.acc_ifu, o.acc_lsu}, {!exp_lsu[t], exp_lsu[t]}); else n_pass++;
            n_checks++; if (o.extra_ready !== 0)
                $display("FAIL rr_ready_once[%0d]: got %0d extra ready cycles expected 0", t, o.extra_ready); else n_pass++;
            n_checks++; if ({o.ifu_rv, o.lsu_rv, o.rdata} !== {!exp_lsu[t], exp_lsu[t], 32'h55 + t})
                $display("FAIL rr_resp[%0d]: got %b%b %h expected %b%b %h", t, o.ifu_rv, o.lsu_rv, o.rdata, !exp_lsu[t], exp_lsu[t], 32'h55 + t); else n_pass++;
        end
    endtask

    task automatic test_timeout();
        obs_t o;
        drive_txn(1'b0, 1'b1, 32'h0, 32'h8000_2000, 1'b0, 32'h0, 4'h0, 3'b010, 0, -1, 32'h0, 0, o);
        m_last_lsu = 1'b1;
        n_checks++; if ({o.wait_len, o.rdata, o.err, o.lsu_rv} !== {32'd4, c_ERR, 2'b11})
            $display("FAIL timeout: got wait=%0d rdata=%h err=%b v=%b expected 4/deadbeef/1/1", o.wait_len, o.rdata, o.err, o.lsu_rv); else n_pass++;
        drive_txn(1'b1, 1'b0, 32'h8000_0004, 32'h0, 1'b0, 32'h0, 4'h0, 3'h0, 0, c_TIMEOUT - 1, 32'hcafe_0001, 0, o);
        m_last_lsu = 1'b0;
        n_checks++; if ({o.wait_len, o.rdata, o.err, o.ifu_rv} !== {32'd4, 32'hcafe_0001, 2'b01})
            $display("FAIL timeout_tie: got wait=%0d rdata=%h err=%b v=%b expected 4/cafe0001/0/1", o.wait_len, o.rdata, o.err, o.ifu_rv); else n_pass++;
    endtask

    task automatic test_backpressure();
        obs_t o;
        // Previous winner is the IFU, so a tie goes to the LSU and the IFU
        // stays pending for the whole transaction.
        drive_txn(1'b1, 1'b1, 32'h8000_0008, 32'h8000_3000, 1'b0, 32'h0, 4'hf, 3'b010, 0, 2, 32'h0bad_f00d, 5, o);
        m_last_lsu = 1'b1;
        n_checks++; if ({o.acc_ifu, o.acc_lsu, o.lsu_rv, o.rdata} !== {3'b011, 32'h0bad_f00d})
            $display("FAIL bp_resp: got acc=%b%b v=%b rdata=%h expected 01/1/0badf00d", o.acc_ifu, o.acc_lsu, o.lsu_rv, o.rdata); else n_pass++;
        n_checks++; if ({o.stable, o.extra_ready} !== {1'b1, 32'd0})
            $display("FAIL bp_hold: got stable=%b extra_ready=%0d expected 1/0", o.stable, o.extra_ready); else n_pass++;
        n_checks++; if (o.idle_after !== 1'b1)
            $display("FAIL bp_release: got idle=%b expected 1", o.idle_after); else n_pass++;
    endtask

    task automatic test_reset_in_wait();
        obs_t o;
        int   late_valid = 0;
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0010;
        tick();
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        tick();
        ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if ({ifu_req_ready, lsu_req_ready, mem_req_valid, ifu_resp_valid, lsu_resp_valid} !== 5'b0)
            $display("FAIL rst_wait_ctrl: got %b expected 00000", {ifu_req_ready, lsu_req_ready, mem_req_valid, ifu_resp_valid, lsu_resp_valid}); else n_pass++;
        n_checks++; if ({mem_addr, ifu_rdata, lsu_rdata} !== 96'h0)
            $display("FAIL rst_wait_data: got %h expected 0", {mem_addr, ifu_rdata, lsu_rdata}); else n_pass++;
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_last_lsu = 1'b1;
        for (int k = 0; k < 6; k++) begin
            mem_resp_valid = 1'b1; mem_rdata = 32'h1111_2222;
            tick();
            late_valid += int'(ifu_resp_valid) + int'(lsu_resp_valid) + int'(mem_req_valid);
        end
        mem_resp_valid = 1'b0;
        n_checks++; if (late_valid !== 0)
            $display("FAIL rst_no_resp: got %0d valid cycles expected 0", late_valid); else n_pass++;
        drive_txn(1'b1, 1'b1, 32'h8000_0020, 32'h8000_4000, 1'b0, 32'h0, 4'h0, 3'b010, 0, 0, 32'h7, 0, o);
        m_last_lsu = 1'b0;
        n_checks++; if ({o.acc_ifu, o.acc_lsu, o.ifu_rv, o.rdata} !== {3'b101, 32'h7})
            $display("FAIL rst_first_grant: got acc=%b%b v=%b rdata=%h expected 10/1/00000007", o.acc_ifu, o.acc_lsu, o.ifu_rv, o.rdata); else n_pass++;
    endtask

    task automatic test_random();
        obs_t        o;
        bit          iv, lv, wl, lwen, timed_out;
        logic [31:0] ia, la, wd, md, e_rdata;
        logic [3:0]  wm;
        logic [2:0]  f3;
        int          stall, rd, bp, e_wait;
        for (int n = 0; n < 30; n++) begin
            iv = 1'($urandom_range(0, 1)); lv = 1'($urandom_range(0, 1));
            if (!iv && !lv) iv = 1'b1;
            ia = $urandom; la = $urandom; wd = $urandom; md = $urandom;
            wm = 4'($urandom); f3 = 3'($urandom); lwen = 1'($urandom_range(0, 1));
            stall = $urandom_range(0, 2);
            rd = $urandom_range(0, 5);
            if (rd == 5) rd = -1;
            bp = $urandom_range(0, 2);
            wl = exp_lsu_wins(iv, lv);
            timed_out = !(rd >= 0 && rd < c_TIMEOUT);
            e_wait = timed_out ? c_TIMEOUT : rd + 1;
            e_rdata = timed_out ? c_ERR : ((wl && lwen) ? 32'h0 : md);
            drive_txn(iv, lv, ia, la, lwen, wd, wm, f3, stall, rd, md, bp, o);
            m_last_lsu = wl;
            n_checks++; if ({o.acc_ifu, o.acc_lsu, o.ifu_rv, o.lsu_rv} !== {!wl, wl, !wl, wl})
                $display("FAIL rand_grant[%0d]: got %b expected %b", n, {o.acc_ifu, o.acc_lsu, o.ifu_rv, o.lsu_rv}, {!wl, wl, !wl, wl}); else n_pass++;
            if (wl) begin
                n_checks++; if ({o.addr, o.wen, o.wdata, o.wmask, o.func3} !== {la, lwen, wd, wm, f3})
                    $display("FAIL rand_lsu_fields[%0d]: got %h expected %h", n, {o.addr, o.wen, o.wdata, o.wmask, o.func3}, {la, lwen, wd, wm, f3}); else n_pass++;
            end else begin
                n_checks++; if ({o.addr, o.wen, o.wmask, o.func3} !== {ia, 1'b0, 4'h0, 3'b010})
                    $display("FAIL rand_ifu_fields[%0d]: got %h expected %h", n, {o.addr, o.wen, o.wmask, o.func3}, {ia, 1'b0, 4'h0, 3'b010}); else n_pass++;
            end
            n_checks++; if ({o.rdata, o.err, o.wait_len} !== {e_rdata, timed_out, e_wait})
                $display("FAIL rand_resp[%0d]: got rdata=%h err=%b wait=%0d expected %h/%b/%0d", n, o.rdata, o.err, o.wait_len, e_rdata, timed_out, e_wait); else n_pass++;
            n_checks++; if ({o.stable, o.idle_after, o.extra_ready} !== {2'b11, 32'd0})
                $display("FAIL rand_flow[%0d]: got stable=%b idle=%b extra_ready=%0d expected 1/1/0", n, o.stable, o.idle_after, o.extra_ready); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_ifu_read();
        test_lsu_store();
        test_back_to_back();
        test_timeout();
        test_backpressure();
        test_reset_in_wait();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far", n_pass, n_checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
